// File: rtl/ac97_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ac97_sample_fifo
// Brief    : Stereo PCM sample FIFO that feeds AC-link slots 3/4 once per frame,
//            with prefill gating and an underrun counter. Define
//            AC97_SAMPLE_FIFO_MONO_EN for 16-bit mono entries (slot4 = slot3).
// Revision : 1.0 - initial release
// ============================================================================
module ac97_sample_fifo #(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8
) (
    input  logic                     ac97_bitclk,
    input  logic                     rst,
    input  logic                     ac97_strobe,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_left,
    input  logic [15:0]              in_right,
    output logic [19:0]              ac97_out_slot3,
    output logic [19:0]              ac97_out_slot4,
    output logic                     ac97_out_slot3_valid,
    output logic                     ac97_out_slot4_valid,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [7:0]               underrun_count
);

    localparam int AW = $clog2(DEPTH);
`ifdef AC97_SAMPLE_FIFO_MONO_EN
    localparam int c_dw = 16;
`else
    localparam int c_dw = 32;
`endif
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_prefill = (AW+1)'(PREFILL);
    localparam logic [AW:0]   c_fill_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    typedef enum logic [0:0] {
        S_FILLING = 1'b0,
        S_RUNNING = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_dw-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_fill;
    logic [19:0]     r_slot3;
    logic            r_valid;
    logic [7:0]      r_underrun;
    logic            w_push;
    logic            w_pop;
    logic            w_underrun;
    logic            w_zero_slots;
    logic [c_dw-1:0] w_wdata;
    logic [c_dw-1:0] w_rdata;

    assign in_ready = (r_fill < c_depth);
    assign w_push   = in_valid && in_ready;
    assign w_rdata  = r_mem[r_rd_ptr];

`ifdef AC97_SAMPLE_FIFO_MONO_EN
    assign w_wdata = in_left;
`else
    assign w_wdata = {in_left, in_right};
`endif

    // Strobe decisions use the fill level before this edge's push, so a
    // sample arriving with the strobe cannot be popped by it.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_underrun   = 1'b0;
        w_zero_slots = 1'b0;
        if (ac97_strobe) begin
            case (r_state)
                S_FILLING: begin
                    if (r_fill >= c_prefill) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_RUNNING;
                    end else begin
                        w_zero_slots = 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (r_fill != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_underrun  = 1'b1;
                        w_state_nxt = S_FILLING;
                    end
                end
                default: w_state_nxt = S_FILLING;
            endcase
        end
    end

    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILLING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_underrun <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + c_fill_one;
                2'b01:   r_fill <= r_fill - c_fill_one;
                default: r_fill <= r_fill;
            endcase
            if (w_underrun && (r_underrun != 8'hFF)) begin
                r_underrun <= r_underrun + 8'd1;
            end
            if (w_pop && (r_state == S_FILLING)) begin
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            r_slot3 <= '0;
        end else if (w_pop) begin
            r_slot3 <= {w_rdata[c_dw-1 -: 16], 4'h0};
        end else if (w_zero_slots) begin
            r_slot3 <= '0;
        end
    end

`ifdef AC97_SAMPLE_FIFO_MONO_EN
    assign ac97_out_slot4 = r_slot3;
`else
    logic [19:0] r_slot4;

    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            r_slot4 <= '0;
        end else if (w_pop) begin
            r_slot4 <= {w_rdata[15:0], 4'h0};
        end else if (w_zero_slots) begin
            r_slot4 <= '0;
        end
    end

    assign ac97_out_slot4 = r_slot4;
`endif

    assign ac97_out_slot3       = r_slot3;
    assign ac97_out_slot3_valid = r_valid;
    assign ac97_out_slot4_valid = r_valid;
    assign fill_level           = r_fill;
    assign underrun_count       = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ac97_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac97_sample_fifo
// Brief    : Directed self-checking bench for ac97_sample_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ac97_sample_fifo;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic [19:0] slot3;
    logic [19:0] slot4;
    logic        slot3_valid;
    logic        slot4_valid;
    logic [4:0]  fill;
    logic [7:0]  underruns;

    int total = 0;
    int bad   = 0;

    ac97_sample_fifo #(.DEPTH(16), .PREFILL(8)) dut (
        .ac97_bitclk          (clk),
        .rst                  (rst),
        .ac97_strobe          (strobe),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_left              (in_left),
        .in_right             (in_right),
        .ac97_out_slot3       (slot3),
        .ac97_out_slot4       (slot4),
        .ac97_out_slot3_valid (slot3_valid),
        .ac97_out_slot4_valid (slot4_valid),
        .fill_level           (fill),
        .underrun_count       (underruns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected slot4 for a sample: right channel in stereo, mirrors slot3 in mono.
    function automatic logic [19:0] exp_s4(input logic [15:0] l, input logic [15:0] r);
`ifdef AC97_SAMPLE_FIFO_MONO_EN
        return {l, 4'h0};
`else
        return {r, 4'h0};
`endif
    endfunction

    task automatic cycle(input logic v, input logic s, input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        in_valid = v;
        strobe   = s;
        in_left  = l;
        in_right = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        strobe   = 1'b0;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        cycle(1'b1, 1'b0, l, r);
    endtask

    task automatic strobe_once();
        cycle(1'b0, 1'b1, 16'h0, 16'h0);
    endtask

    initial begin
        rst      = 1'b1;
        strobe   = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        #23;
        check("rst_slot3", slot3, 0);
        check("rst_slot4", slot4, 0);
        check("rst_valids", {slot3_valid, slot4_valid}, 0);
        check("rst_fill", fill, 0);
        check("rst_underrun", underruns, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Strobes with an empty FIFO stay in FILLING
        for (int i = 0; i < 3; i++) strobe_once();
        check("idle_slot3", slot3, 0);
        check("idle_slot4", slot4, 0);
        check("idle_valids", {slot3_valid, slot4_valid}, 0);
        check("idle_underrun", underruns, 0);

        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        check("prefill_fill", fill, 8);
        strobe_once();
        check("start_slot3", slot3, 20'h10000);
        check("start_slot4", slot4, exp_s4(16'h1000, 16'h2000));
        check("start_valids", {slot3_valid, slot4_valid}, 2'b11);
        check("start_fill", fill, 7);

        for (int i = 8; i < 17; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        check("full_fill", fill, 16);
        check("full_ready", in_ready, 0);
        push(16'hDEAD, 16'hBEEF);
        check("full_reject_fill", fill, 16);
        strobe_once();
        check("after_full_slot3", slot3, 20'h10010);
        check("after_full_fill", fill, 15);
        check("after_full_ready", in_ready, 1);

        strobe_once();
        check("drain_first_slot3", slot3, 20'h10020);
        for (int i = 0; i < 14; i++) strobe_once();
        check("drain_last_slot3", slot3, 20'h10100);
        check("drain_last_slot4", slot4, exp_s4(16'h1010, 16'h2010));
        check("drain_fill", fill, 0);

        strobe_once();
        check("underrun_hold_slot3", slot3, 20'h10100);
        check("underrun_hold_slot4", slot4, exp_s4(16'h1010, 16'h2010));
        check("underrun_count1", underruns, 1);

        push(16'h3000, 16'h4000);
        for (int i = 0; i < 7; i++) strobe_once();
        check("refill_slot3", slot3, 0);
        check("refill_slot4", slot4, 0);
        check("refill_underrun", underruns, 1);
        check("refill_fill", fill, 1);
        check("refill_valids", {slot3_valid, slot4_valid}, 2'b11);

        for (int i = 1; i < 8; i++) push(16'h3000 + 16'(i), 16'h4000 + 16'(i));
        strobe_once();
        check("resume_slot3", slot3, 20'h30000);
        check("resume_slot4", slot4, exp_s4(16'h3000, 16'h4000));
        check("resume_fill", fill, 7);
        for (int i = 0; i < 8; i++) strobe_once();
        check("underrun_count2", underruns, 2);

        // 297 more full fill/drain/underrun rounds -> 299 events
        for (int k = 0; k < 297; k++) begin
            for (int i = 0; i < 8; i++) push(16'h5000 + 16'(i), 16'h6000 + 16'(i));
            for (int i = 0; i < 9; i++) strobe_once();
        end
        check("sat_underrun", underruns, 8'hFF);
        for (int i = 0; i < 8; i++) push(16'h5100 + 16'(i), 16'h6100 + 16'(i));
        for (int i = 0; i < 8; i++) strobe_once();
        check("pre_coincident_fill", fill, 0);
        cycle(1'b1, 1'b1, 16'h5555, 16'h6666);
        check("coincident_fill", fill, 1);
        check("coincident_underrun", underruns, 8'hFF);
        check("coincident_slot3", slot3, 20'h51070);

        for (int i = 0; i < 4; i++) push(16'h7700, 16'h7700);
        check("pre_reset_fill", fill, 5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_slot3", slot3, 0);
        check("async_rst_slot4", slot4, 0);
        check("async_rst_valids", {slot3_valid, slot4_valid}, 0);
        check("async_rst_fill", fill, 0);
        check("async_rst_underrun", underruns, 0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) push(16'h7000 + 16'(i), 16'h8000 + 16'(i));
        strobe_once();
        check("post_rst_slot3", slot3, 20'h70000);
        check("post_rst_slot4", slot4, exp_s4(16'h7000, 16'h8000));
        check("post_rst_fill", fill, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ac97_sample_fifo.md
AC97_SAMPLE_FIFO -- requirements
Module: ac97_sample_fifo

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; power of two, 4 to 64.
REQ-002 Parameter: PREFILL, 8, entries required before playback starts or resumes; range 1 to DEPTH.
REQ-003 Port: ac97_bitclk  in  1  codec bit clock; the only clock.
REQ-004 Port: rst  in  1  reset; asynchronous, active-high.
REQ-005 Port: ac97_strobe  in  1  frame strobe from the AC-link framer; high one cycle per 256-bit frame.
REQ-006 Port: in_valid  in  1  producer (sound mixer) sample offered.
REQ-007 Port: in_ready  out  1  FIFO can accept a sample this cycle.
REQ-008 Port: in_left  in  16  left PCM sample, signed two's complement.
REQ-009 Port: in_right  in  16  right PCM sample, signed two's complement.
REQ-010 Port: ac97_out_slot3  out  20  left PCM slot to the framer.
REQ-011 Port: ac97_out_slot4  out  20  right PCM slot to the framer.
REQ-012 Port: ac97_out_slot3_valid  out  1  slot 3 tag bit.
REQ-013 Port: ac97_out_slot4_valid  out  1  slot 4 tag bit.
REQ-014 Port: fill_level  out  log2(DEPTH)+1  current entry count.
REQ-015 Port: underrun_count  out  8  saturating count of underrun events.

Function
REQ-016 Storage: DEPTH x 32-bit entries {left,right}; circular read/write pointers wrap modulo DEPTH.
REQ-017 Push handshake: a push occurs on a clock edge where in_valid && in_ready. Data is sampled at that edge.
REQ-018 in_ready: combinational, equal to (fill_level < DEPTH). Push while full is impossible; data offered while full is not consumed.
REQ-019 FSM states: FILLING and RUNNING. The FSM enters FILLING from reset.
REQ-020 FILLING -> RUNNING: on the first strobe where fill_level >= PREFILL.
  - That strobe pops an entry and outputs it.
  - No underrun is counted in FILLING.
REQ-021 FILLING strobe with fill_level < PREFILL: no pop; slot3 and slot4 are driven to 20'h0.
REQ-022 RUNNING strobe with fill_level > 0:
  - Pop one entry.
  - slot3 <= {left,4'h0}; slot4 <= {right,4'h0}.
REQ-023 RUNNING strobe with fill_level == 0 (underrun):
  - Slot registers hold their previous values.
  - underrun_count increments, saturating at 8'hFF.
  - FSM moves to FILLING.
REQ-024 Latency: slot registers update on the edge where ac97_strobe is sampled high and are stable for the remaining 255 bit clocks. Data pushed at the same edge as a strobe is not eligible for that strobe's pop.
REQ-025 Simultaneous push and pop: fill_level is unchanged; both pointers advance.
REQ-026 Simultaneous push and underrun strobe: the push is stored, fill_level becomes 1, and the underrun is still counted.
REQ-027 Slot valid bits: registered. They go to 1 at the first transition into RUNNING and remain 1 until reset.
REQ-028 Non-strobe cycles: slot registers, valid bits and FSM state do not change. Only pushes modify state.

Reset
REQ-029 While rst is high, asynchronously:
  - Pointers = 0, fill_level = 0, state = FILLING.
  - ac97_out_slot3 = ac97_out_slot4 = 20'h0.
  - Both valid bits = 0; underrun_count = 0; in_ready = 1 after release.
REQ-030 Reset mid-frame or mid-push discards all FIFO contents. No partial push is retained.

Configuration
REQ-031 Macro AC97_SAMPLE_FIFO_MONO_EN: when defined, entries are 16 bits, in_right is ignored, and ac97_out_slot4 always equals ac97_out_slot3.
REQ-032 When AC97_SAMPLE_FIFO_MONO_EN is undefined, full stereo operation applies as specified above.

Verification
REQ-033 Reset, 3 strobes, no pushes -> slots 20'h0, valids 0, underrun_count 0, state FILLING.
REQ-034 Push 8 samples with left=16'h1000+i and right=16'h2000+i, then strobe ->
  - slot3=20'h10000, slot4=20'h20000, valids 1, fill_level 7.
REQ-035 Push 16 samples with no strobe -> in_ready 0 and fill_level 16. A 17th offered sample is not accepted; after one strobe, in_ready returns to 1.
REQ-036 In RUNNING, drain to empty, then strobe ->
  - Slots hold the last sample; underrun_count=1; state FILLING.
  - The next 7 strobes with fill_level<8 output 20'h0 and leave underrun_count at 1.
REQ-037 Force 300 underrun events -> underrun_count saturates at 8'hFF. A push coincident with the strobe edge leaves fill_level=1.
REQ-038 Assert rst mid-frame with fill_level=5 -> all outputs return to reset values immediately, fill_level=0; with AC97_SAMPLE_FIFO_MONO_EN defined, slot4 tracks slot3 in every scenario above.
